// File: rtl/chunk_stats_if.sv
// Bundle of the chunk-queue, sample-read and result handshake signals of chunk_stats.
// master is the chunk_stats side, slave is the surrounding queue/store/consumer side.
interface chunk_stats_if #(
  parameter int AW = 32
);
  logic          q_empty;
  logic [AW-1:0] qSout;
  logic [AW-1:0] qEout;
  logic [AW-1:0] qIDout;
  logic          qPop;
  logic [AW-1:0] varIndx;
  logic [31:0]   var_data;
  logic          res_valid;
  logic          res_ready;
  logic [AW-1:0] res_id;
  logic [31:0]   res_mean;
  logic [31:0]   res_var;
  logic          res_err;
  logic          busy;

  modport master (
    input  q_empty, qSout, qEout, qIDout, var_data, res_ready,
    output qPop, varIndx, res_valid, res_id, res_mean, res_var, res_err, busy
  );

  modport slave (
    output q_empty, qSout, qEout, qIDout, var_data, res_ready,
    input  qPop, varIndx, res_valid, res_id, res_mean, res_var, res_err, busy
  );
endinterface

// File: rtl/chunk_stats.sv
// Integer mean and variance over one chunk of 16-bit unsigned samples at a time,
// using a single shared restoring divider for sum/len and sumsq/len.
module chunk_stats #(
  parameter int AW   = 32,
  parameter int DIVW = 48
) (
  input  logic          Clk,
  input  logic          Rst,
  chunk_stats_if.master bus
);
  localparam int DCW = $clog2(DIVW);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_READ, S_DRAIN, S_DIVM, S_DIVV, S_FIN, S_OUT
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   si_q, si_d, ei_q, ei_d, id_q, id_d;
  logic [AW-1:0]   len_q, len_d, cnt_q, cnt_d, varindx_q, varindx_d;
  logic [AW-1:0]   res_id_q, res_id_d;
  logic [31:0]     sum_q, sum_d, qv_q, qv_d;
  logic [31:0]     res_mean_q, res_mean_d, res_var_q, res_var_d;
  logic [DIVW-1:0] sumsq_q, sumsq_d, rem_q, rem_d, quo_q, quo_d;
  logic [DCW-1:0]  dcnt_q, dcnt_d;
  logic            vld_p1_q, vld_p1_d, res_err_q, res_err_d;
  logic            qpop;

  logic [AW-1:0]     lo, hi;
  logic [31:0]       smp, smp_sq, sum_acc, mean_sq;
  logic [DIVW-1:0]   sumsq_acc, len_x, step_rem, step_quo;
  logic [2*DIVW-1:0] step;
  logic              unused_var_hi;

  assign unused_var_hi = ^bus.var_data[31:16];

  // One restoring-division iteration: shift in the next dividend bit, subtract if it fits.
  function automatic logic [2*DIVW-1:0] div_step(input logic [DIVW-1:0] rem,
                                                 input logic [DIVW-1:0] quo,
                                                 input logic [DIVW-1:0] den);
    logic [DIVW-1:0] r;
    logic [DIVW-1:0] q;
    r = {rem[DIVW-2:0], quo[DIVW-1]};
    q = {quo[DIVW-2:0], 1'b0};
    if (r >= den) begin
      r    = r - den;
      q[0] = 1'b1;
    end
    return {r, q};
  endfunction

  always_comb begin
    lo        = (si_q <= ei_q) ? si_q : ei_q;
    hi        = (si_q <= ei_q) ? ei_q : si_q;
    smp       = {16'd0, bus.var_data[15:0]};
    smp_sq    = smp * smp;
    sum_acc   = vld_p1_q ? (sum_q + smp) : sum_q;
    sumsq_acc = vld_p1_q ? (sumsq_q + {{(DIVW-32){1'b0}}, smp_sq}) : sumsq_q;
    len_x     = {{(DIVW-AW){1'b0}}, len_q};
    step      = div_step(rem_q, quo_q, len_x);
    step_rem  = step[2*DIVW-1:DIVW];
    step_quo  = step[DIVW-1:0];
    mean_sq   = {16'd0, res_mean_q[15:0]} * {16'd0, res_mean_q[15:0]};

    state_d    = state_q;
    si_d       = si_q;
    ei_d       = ei_q;
    id_d       = id_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    varindx_d  = varindx_q;
    sum_d      = sum_acc;
    sumsq_d    = sumsq_acc;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dcnt_d     = dcnt_q;
    qv_d       = qv_q;
    vld_p1_d   = 1'b0;
    res_id_d   = res_id_q;
    res_mean_d = res_mean_q;
    res_var_d  = res_var_q;
    res_err_d  = res_err_q;
    qpop       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!bus.q_empty) begin
          qpop    = 1'b1;
          si_d    = bus.qSout;
          ei_d    = bus.qEout;
          id_d    = bus.qIDout;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        len_d      = hi - lo;
        cnt_d      = hi - lo;
        sum_d      = '0;
        sumsq_d    = '0;
        res_id_d   = id_q;
        res_mean_d = '0;
        res_var_d  = '0;
        res_err_d  = (hi == lo);
        if (hi == lo) begin
          state_d = S_OUT;
        end else begin
          varindx_d = lo;
          state_d   = S_READ;
        end
      end
      // Address stage: sample for this address is accumulated one cycle later (vld_p1).
      S_READ: begin
        vld_p1_d = 1'b1;
        if (cnt_q == AW'(1)) begin
          state_d = S_DRAIN;
        end else begin
          varindx_d = varindx_q + AW'(1);
          cnt_d     = cnt_q - AW'(1);
        end
      end
      S_DRAIN: begin
        quo_d   = {{(DIVW-32){1'b0}}, sum_acc};
        rem_d   = '0;
        dcnt_d  = '0;
        state_d = S_DIVM;
      end
      S_DIVM: begin
        rem_d  = step_rem;
        quo_d  = step_quo;
        dcnt_d = dcnt_q + DCW'(1);
        if (dcnt_q == DCW'(DIVW-1)) begin
          res_mean_d = step_quo[31:0];
          quo_d      = sumsq_q;
          rem_d      = '0;
          dcnt_d     = '0;
          state_d    = S_DIVV;
        end
      end
      S_DIVV: begin
        rem_d  = step_rem;
        quo_d  = step_quo;
        dcnt_d = dcnt_q + DCW'(1);
        if (dcnt_q == DCW'(DIVW-1)) begin
          qv_d    = step_quo[31:0];
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        res_var_d = qv_q - mean_sq;
        state_d   = S_OUT;
      end
      S_OUT: begin
        if (bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      varindx_q  <= '0;
      cnt_q      <= '0;
      dcnt_q     <= '0;
      vld_p1_q   <= 1'b0;
      res_id_q   <= '0;
      res_mean_q <= '0;
      res_var_q  <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      varindx_q  <= varindx_d;
      cnt_q      <= cnt_d;
      dcnt_q     <= dcnt_d;
      vld_p1_q   <= vld_p1_d;
      res_id_q   <= res_id_d;
      res_mean_q <= res_mean_d;
      res_var_q  <= res_var_d;
      res_err_q  <= res_err_d;
    end
  end

  always_ff @(posedge Clk) begin
    si_q    <= si_d;
    ei_q    <= ei_d;
    id_q    <= id_d;
    len_q   <= len_d;
    sum_q   <= sum_d;
    sumsq_q <= sumsq_d;
    rem_q   <= rem_d;
    quo_q   <= quo_d;
    qv_q    <= qv_d;
  end

  assign bus.qPop      = qpop & ~Rst;
  assign bus.varIndx   = varindx_q;
  assign bus.res_valid = (state_q == S_OUT);
  assign bus.res_id    = res_id_q;
  assign bus.res_mean  = res_mean_q;
  assign bus.res_var   = res_var_q;
  assign bus.res_err   = res_err_q;
  assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_chunk_stats.sv
// Randomized bench for chunk_stats: queue and sample-store models, a scoreboard of
// expected results computed directly from the chunk's samples, and latency/address checks.
module tb_chunk_stats;
  logic Clk = 1'b0;
  logic Rst;

  chunk_stats_if #(.AW(32)) bus ();

  chunk_stats #(.AW(32), .DIVW(48)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  logic [31:0] mem [0:65535];
  always @(posedge Clk) bus.var_data <= mem[bus.varIndx[15:0]];

  typedef struct {
    logic [31:0] s, e, id;
  } desc_t;

  typedef struct {
    logic [31:0] id, mean, v, lo;
    logic        err;
    int          pop;
    int          len;
  } exp_t;

  localparam int LOGN = 100000;

  desc_t       dq[$];
  exp_t        exp_q[$];
  logic [31:0] addr_log [0:LOGN-1];
  int          n_tests = 0, n_fail = 0, cyc = 0, pop_cyc = -1, last_gap = 0, rise_cyc = 0;
  bit          rand_ready = 0;
  logic        s_pop, s_valid, s_ready, s_err, s_busy, s_rst, s_qe;
  logic [31:0] s_id, s_mean, s_var, s_addr;
  logic        p_valid = 1'b0, p_hs = 1'b0, p_err;
  logic [31:0] p_id, p_mean, p_var;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: direct statistics of the chunk's samples.
  function automatic exp_t model(input desc_t d, input int pc);
    exp_t e;
    longint unsigned sum, sq, m;
    logic [31:0] lo, hi;
    lo    = (d.s < d.e) ? d.s : d.e;
    hi    = (d.s < d.e) ? d.e : d.s;
    e.id  = d.id;
    e.lo  = lo;
    e.len = int'(hi - lo);
    e.pop = pc;
    e.err = (e.len == 0);
    sum   = 0;
    sq    = 0;
    for (int i = 0; i < e.len; i++) begin
      m    = longint'(mem[int'(lo) + i][15:0]);
      sum += m;
      sq  += m * m;
    end
    if (e.len == 0) begin
      e.mean = 0;
      e.v    = 0;
    end else begin
      m      = sum / longint'(e.len);
      e.mean = 32'(m);
      e.v    = 32'(sq / longint'(e.len) - m * m);
    end
    return e;
  endfunction

  task automatic refresh();
    if (dq.size() == 0) begin
      bus.q_empty = 1'b1;
    end else begin
      bus.q_empty = 1'b0;
      bus.qSout   = dq[0].s;
      bus.qEout   = dq[0].e;
      bus.qIDout  = dq[0].id;
    end
  endtask

  task automatic push(input logic [31:0] s, input logic [31:0] e, input logic [31:0] id);
    desc_t d;
    d.s = s; d.e = e; d.id = id;
    dq.push_back(d);
    refresh();
  endtask

  task automatic tick();
    exp_t e;
    int   bad;
    @(negedge Clk);
    s_pop = bus.qPop;   s_valid = bus.res_valid; s_ready = bus.res_ready;
    s_id  = bus.res_id; s_mean  = bus.res_mean;  s_var   = bus.res_var;
    s_err = bus.res_err; s_busy = bus.busy;      s_addr  = bus.varIndx;
    s_rst = Rst;        s_qe    = bus.q_empty;
    if (cyc < LOGN) addr_log[cyc] = s_addr;
    if (s_rst) begin
      check_val("pop_in_reset", s_pop, 0);
    end else begin
      if (s_valid === 1'b1 && p_valid !== 1'b1) rise_cyc = cyc;
      if (s_valid === 1'b1 && p_valid === 1'b1 && !p_hs)
        check_val("hold_stable", {s_id, s_mean, s_var, s_err}, {p_id, p_mean, p_var, p_err});
      if (s_pop === 1'b1) begin
        check_val("pop_not_empty", s_qe, 0);
        check_val("pop_after_accept", exp_q.size(), 0);
        if (dq.size() > 0) exp_q.push_back(model(dq[0], cyc));
        if (pop_cyc >= 0) last_gap = cyc - pop_cyc;
        pop_cyc = cyc;
      end
      if (s_valid === 1'b1 && s_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check_val("spurious_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_val("res_id", s_id, e.id);
          check_val("res_mean", s_mean, e.mean);
          check_val("res_var", s_var, e.v);
          check_val("res_err", s_err, e.err);
          check_val("latency", rise_cyc - e.pop, (e.len == 0) ? 2 : e.len + 100);
          if (!e.err) begin
            bad = 0;
            for (int i = 0; i < e.len; i++) begin
              if (e.pop + 2 + i < LOGN && addr_log[e.pop + 2 + i] !== e.lo + 32'(i)) bad++;
            end
            check_val("addr_seq", bad, 0);
          end
        end
      end
    end
    p_hs    = (s_valid === 1'b1) && (s_ready === 1'b1) && !s_rst;
    p_valid = s_rst ? 1'b0 : s_valid;
    p_id = s_id; p_mean = s_mean; p_var = s_var; p_err = s_err;
    @(posedge Clk);
    #1;
    cyc++;
    if (s_pop === 1'b1 && !s_rst && dq.size() > 0) void'(dq.pop_front());
    refresh();
    if (rand_ready) bus.res_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic run_until_idle(input int maxc);
    for (int i = 0; i < maxc && (dq.size() != 0 || exp_q.size() != 0); i++) tick();
    check_val("drain_timeout", (dq.size() != 0 || exp_q.size() != 0), 0);
    tick();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_qpop"}, s_pop, 0);
    check_val({pfx, "_valid"}, s_valid, 0);
    check_val({pfx, "_addr"}, s_addr, 0);
    check_val({pfx, "_id"}, s_id, 0);
    check_val({pfx, "_mean"}, s_mean, 0);
    check_val({pfx, "_var"}, s_var, 0);
    check_val({pfx, "_err"}, s_err, 0);
    check_val({pfx, "_busy"}, s_busy, 0);
  endtask

  initial begin
    int s, e, pc0;
    Rst           = 1'b1;
    bus.res_ready = 1'b1;
    bus.q_empty   = 1'b1;
    bus.qSout     = '0;
    bus.qEout     = '0;
    bus.qIDout    = '0;
    for (int i = 0; i < 65536; i++) mem[i] = {16'($urandom), 16'(i)};
    refresh();
    tick();
    tick();
    check_reset_outputs("reset");
    Rst = 1'b0;

    push(0, 4, 7);
    run_until_idle(300);
    push(4, 2, 3);
    run_until_idle(300);
    push(5, 5, 9);
    run_until_idle(50);

    push(1, 1, 20);
    push(7, 7, 21);
    push(9, 9, 22);
    run_until_idle(50);
    check_val("zero_gap", last_gap, 3);

    rand_ready = 1;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      s = $urandom_range(0, 200);
      e = s + $urandom_range(0, 40);
      if ($urandom_range(0, 1) == 1) push(32'(e), 32'(s), 32'(100 + k));
      else                           push(32'(s), 32'(e), 32'(100 + k));
      if ($urandom_range(0, 1) == 1) push(32'(e), 32'(s), 32'(200 + k));
      run_until_idle(2000);
    end
    rand_ready    = 0;
    bus.res_ready = 1'b1;

    for (int i = 0; i < 4; i++) mem[i] = {16'hABCD, 16'hFFFF};
    push(0, 4, 11);
    run_until_idle(300);

    for (int i = 0; i < 256; i++) mem[i] = {16'($urandom), 16'(i)};
    bus.res_ready = 1'b0;
    push(10, 14, 30);
    push(20, 13, 31);
    for (int i = 0; i < 300 && s_valid !== 1'b1; i++) tick();
    check_val("bp_valid_seen", s_valid, 1);
    repeat (20) tick();
    check_val("bp_queue_held", dq.size(), 1);
    bus.res_ready = 1'b1;
    run_until_idle(600);

    pc0 = pop_cyc;
    push(30, 46, 40);
    push(50, 53, 41);
    for (int i = 0; i < 20 && pop_cyc == pc0; i++) tick();
    check_val("rst_test_pop_seen", (pop_cyc != pc0), 1);
    for (int i = 0; i < 20 && cyc < pop_cyc + 10; i++) tick();
    Rst = 1'b1;
    tick();
    tick();
    check_reset_outputs("midrst");
    check_val("midrst_queue_kept", dq.size(), 1);
    Rst = 1'b0;
    exp_q.delete();
    run_until_idle(300);

    for (int i = 0; i < 65536; i++) mem[i] = {16'($urandom), 16'(i)};
    push(0, 65535, 50);
    run_until_idle(66000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
